// File: rtl/conf_frame_deserializer_pkg.sv
// rtl/conf_frame_deserializer_pkg.sv - shared constants, state encoding and frame-size helpers
//
// Purpose: state encoding, default timeouts and NA/ND/NT byte-count
// derivation used by conf_frame_deserializer and its timer.

package conf_frame_deserializer_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_WRITE   = 1'b1
    } state_e;

    localparam int unsigned DEF_ADDR_WIDTH   = 16;
    localparam int unsigned DEF_DATA_WIDTH   = 16;
    localparam int unsigned DEF_ACK_TIMEOUT  = 16;
    localparam int unsigned DEF_BYTE_TIMEOUT = 1000;

    // Address bytes per frame.
    function automatic int unsigned frame_na(input int unsigned addr_width);
        return addr_width / 8;
    endfunction

    // Data bytes per frame.
    function automatic int unsigned frame_nd(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Total bytes per frame.
    function automatic int unsigned frame_nt(input int unsigned addr_width,
                                             input int unsigned data_width);
        return frame_na(addr_width) + frame_nd(data_width);
    endfunction

    // Bits needed to hold a byte index 0..nt-1.
    function automatic int unsigned idx_width(input int unsigned nt);
        return (nt > 1) ? $clog2(nt) : 1;
    endfunction

endpackage

// File: rtl/conf_frame_deserializer_timeout_counter.sv
// rtl/conf_frame_deserializer_timeout_counter.sv - saturating cycle counter with terminal-count flag
//
// Purpose: counts enabled cycles from zero; tc_o is high while enabled and the
// count equals LIMIT. The count saturates at LIMIT so tc_o stays meaningful
// until the owner clears it.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-low reset
//   clr_i  - clear count to zero (wins over enable)
//   en_i   - count this cycle
//   tc_o   - terminal count reached (combinational)

module timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_limit;

    assign at_limit = (cnt_q == CW'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && at_limit;

endmodule

// File: rtl/conf_frame_deserializer.sv
// rtl/conf_frame_deserializer.sv - byte-stream to register-write frame deserializer
//
// Purpose: assembles NA address bytes and ND data bytes (MSB first) from a
// ready/ack byte stream into one register write, holds it on si_* until
// acknowledged or timed out, and discards partial frames after an idle gap.
// Ports:
//   clk, rst             - clock and synchronous active-low reset
//   rx_data/rx_rdy/rx_ack - byte input handshake (rx_ack combinational)
//   si_addr/si_data/si_rdy/si_ack - register write request and acknowledge
//   err_nack             - one-cycle pulse, write was never acknowledged
//   err_frame            - one-cycle pulse, partial frame dropped on gap timeout

module conf_frame_deserializer
    import conf_frame_deserializer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
    parameter int unsigned BYTE_TIMEOUT = DEF_BYTE_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  rx_ack,
    output logic [ADDR_WIDTH-1:0] si_addr,
    output logic [DATA_WIDTH-1:0] si_data,
    output logic                  si_rdy,
    input  logic                  si_ack,
    output logic                  err_nack,
    output logic                  err_frame
);

    localparam int unsigned NA = frame_na(ADDR_WIDTH);
    localparam int unsigned NT = frame_nt(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned IW = idx_width(NT);

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_nack_q, err_nack_d;
    logic                  err_frame_q, err_frame_d;

    logic                  in_collect;
    logic                  capture;
    logic [IW-1:0]         base_idx;
    logic                  ack_tc;
    logic                  gap_tc;
    logic                  gap_en;
    logic                  gap_clr;

    assign in_collect = (state_q == ST_COLLECT);
    assign rx_ack     = rx_rdy & in_collect & rst;
    assign capture    = rx_ack;

    // Ack timer runs only in WRITE. Its count equals the number of completed
    // WRITE cycles, so a limit of ACK_TIMEOUT-1 fires in the last allowed cycle
    // and si_rdy is high for exactly ACK_TIMEOUT cycles.
    timeout_counter #(
        .LIMIT (ACK_TIMEOUT - 1)
    ) u_ack_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (in_collect),
        .en_i  (!in_collect),
        .tc_o  (ack_tc)
    );

    // Gap timer counts idle cycles since the last capture of a partial frame.
    // It is sampled in the capture cycle too, so a byte that arrives exactly
    // when the gap expires starts a new frame.
    assign gap_en  = in_collect && (idx_q != '0);
    assign gap_clr = !gap_en || capture || gap_tc;

    timeout_counter #(
        .LIMIT (BYTE_TIMEOUT)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (gap_clr),
        .en_i  (gap_en),
        .tc_o  (gap_tc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        err_nack_d  = 1'b0;
        err_frame_d = 1'b0;
        base_idx    = idx_q;

        unique case (state_q)
            ST_COLLECT: begin
                if (gap_tc) begin
                    err_frame_d = 1'b1;
                    base_idx    = '0;
                    idx_d       = '0;
                end
                if (capture) begin
                    if (base_idx < IW'(NA)) begin
                        addr_d = (addr_q << 8) | ADDR_WIDTH'(rx_data);
                    end else begin
                        data_d = (data_q << 8) | DATA_WIDTH'(rx_data);
                    end
                    if (base_idx == IW'(NT - 1)) begin
                        state_d = ST_WRITE;
                        idx_d   = '0;
                    end else begin
                        idx_d = base_idx + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                // An ack on the timeout edge still counts as a successful write.
                if (si_ack) begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                end else if (ack_tc) begin
                    state_d    = ST_COLLECT;
                    idx_d      = '0;
                    err_nack_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_COLLECT;
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            err_nack_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            err_nack_q  <= err_nack_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign si_addr   = addr_q;
    assign si_data   = data_q;
    assign si_rdy    = (state_q == ST_WRITE);
    assign err_nack  = err_nack_q;
    assign err_frame = err_frame_q;

endmodule

// File: tb/tb_conf_frame_deserializer.sv
// tb/tb_conf_frame_deserializer.sv - self-checking bench for conf_frame_deserializer

module tb_conf_frame_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    wire         rx_ack;
    wire  [15:0] si_addr;
    wire  [15:0] si_data;
    wire         si_rdy;
    wire         si_ack;
    wire         err_nack;
    wire         err_frame;

    always #5 clk = ~clk;

    conf_frame_deserializer dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .rx_ack    (rx_ack),
        .si_addr   (si_addr),
        .si_data   (si_data),
        .si_rdy    (si_rdy),
        .si_ack    (si_ack),
        .err_nack  (err_nack),
        .err_frame (err_frame)
    );

    int passed = 0;
    int total  = 0;

    // Register bank stand-in: unmapped addresses never ack; data D0xx..DFxx
    // delays the ack by data[4:0] cycles after si_rdy rises.
    function automatic bit mapped(input logic [15:0] a);
        return (a != 16'h0077) && (a[15:14] != 2'b11);
    endfunction

    function automatic int dly(input logic [15:0] d);
        return (d[15:12] == 4'hD) ? int'(d[4:0]) : 0;
    endfunction

    int rdy_cnt = 0;
    always @(posedge clk) rdy_cnt <= si_rdy ? rdy_cnt + 1 : 0;
    assign si_ack = si_rdy && mapped(si_addr) && (rdy_cnt >= dly(si_data));

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          width;
        bit          nack;
    } wr_t;

    wr_t obs[$];
    wr_t cur;
    bit  in_wr     = 1'b0;
    int  frame_cnt = 0;
    int  viol      = 0;
    int  stab      = 0;

    always @(negedge clk) begin
        wr_t tmp;
        if (si_rdy) begin
            if (!in_wr) begin
                in_wr     = 1'b1;
                cur.addr  = si_addr;
                cur.data  = si_data;
                cur.width = 0;
                cur.nack  = 1'b0;
            end else if (si_addr != cur.addr || si_data != cur.data) begin
                stab++;
            end
            cur.width++;
            if (rx_ack) viol++;
        end else if (in_wr) begin
            in_wr = 1'b0;
            obs.push_back(cur);
        end
        if (err_nack && obs.size() > 0) begin
            tmp      = obs.pop_back();
            tmp.nack = 1'b1;
            obs.push_back(tmp);
        end
        if (err_frame) frame_cnt++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken,
    // leaving rx_rdy high so a following byte streams without a gap.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done    = 1'b0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            #1;
            done = rx_ack;
            @(negedge clk);
        end
        if (!done) chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        rx_rdy = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] d);
        logic [31:0] w;
        w = {a, d};
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
    endtask

    task automatic wait_writes(input int n);
        rx_rdy = 1'b0;
        for (int c = 0; c < 300 && obs.size() < n; c++) @(negedge clk);
        idle(4);
    endtask

    task automatic chk_write(input string nm, input int i, input logic [15:0] a,
                             input logic [15:0] d, input int w, input bit nk);
        if (obs.size() > i) begin
            chk({nm, "_addr"}, obs[i].addr, a);
            chk({nm, "_data"}, obs[i].data, d);
            chk({nm, "_width"}, obs[i].width, w);
            chk({nm, "_nack"}, obs[i].nack, nk);
        end else begin
            chk({nm, "_present"}, 0, 1);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        int          gap_pos;
        int          gap_len;
        int          ew;
        bit          en;
        int          ef;
    } vec_t;

    vec_t vt[6];

    initial begin
        int   base;
        int   fb;
        int   vb;
        logic [31:0] w;
        wr_t  expq[$];
        wr_t  e;
        logic [15:0] ra;
        logic [15:0] rd;

        vt[0] = '{16'h000A, 16'h1234, 0, 0,   1,  1'b0, 0};
        vt[1] = '{16'h0077, 16'hABCD, 0, 0,   16, 1'b1, 0};
        vt[2] = '{16'h000A, 16'hD00F, 0, 0,   16, 1'b0, 0};
        vt[3] = '{16'h000A, 16'hD010, 0, 0,   16, 1'b1, 0};
        vt[4] = '{16'h0102, 16'hD005, 2, 999, 6,  1'b0, 0};
        vt[5] = '{16'hC000, 16'h0001, 3, 3,   16, 1'b1, 0};

        rst     = 1'b0;
        rx_rdy  = 1'b1;
        rx_data = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_rx_ack", rx_ack, 0);
        chk("rst_si_rdy", si_rdy, 0);
        chk("rst_si_addr", si_addr, 0);
        chk("rst_si_data", si_data, 0);
        chk("rst_err_nack", err_nack, 0);
        chk("rst_err_frame", err_frame, 0);
        rst    = 1'b1;
        rx_rdy = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            base = obs.size();
            fb   = frame_cnt;
            w    = {vt[i].a, vt[i].d};
            for (int k = 0; k < 4; k++) begin
                if (vt[i].gap_len > 0 && k == vt[i].gap_pos) idle(vt[i].gap_len);
                send_byte(w[31-8*k -: 8]);
            end
            wait_writes(base + 1);
            chk_write($sformatf("vec%0d", i), base, vt[i].a, vt[i].d, vt[i].ew, vt[i].en);
            chk($sformatf("vec%0d_count", i), obs.size(), base + 1);
            chk($sformatf("vec%0d_frame_err", i), frame_cnt - fb, vt[i].ef);
        end

        // Partial frame expires after a 1000-cycle gap; the byte arriving on
        // the expiry edge opens the next frame.
        base = obs.size();
        fb   = frame_cnt;
        send_byte(8'h00);
        send_byte(8'h0A);
        idle(1000);
        send_frame(16'h000B, 16'h55AA);
        wait_writes(base + 1);
        chk("gap_frame_err", frame_cnt - fb, 1);
        chk("gap_count", obs.size(), base + 1);
        chk_write("gap", base, 16'h000B, 16'h55AA, 1, 1'b0);

        // Next frame streamed during a WRITE with a delayed ack.
        base = obs.size();
        vb   = viol;
        send_frame(16'h000A, 16'hD005);
        send_frame(16'h000C, 16'h0042);
        wait_writes(base + 2);
        chk("bp_count", obs.size(), base + 2);
        chk("bp_rx_ack_in_write", viol - vb, 0);
        chk_write("bp_first", base, 16'h000A, 16'hD005, 6, 1'b0);
        chk_write("bp_second", base + 1, 16'h000C, 16'h0042, 1, 1'b0);

        // Reset in the middle of a frame abandons it silently.
        base = obs.size();
        fb   = frame_cnt;
        send_byte(8'h00);
        send_byte(8'h0A);
        send_byte(8'h12);
        rst     = 1'b0;
        rx_rdy  = 1'b1;
        rx_data = 8'h34;
        #1;
        chk("mid_rst_rx_ack", rx_ack, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_si_addr", si_addr, 0);
        chk("mid_rst_si_data", si_data, 0);
        rst = 1'b1;
        idle(1100);
        chk("mid_rst_no_frame_err", frame_cnt - fb, 0);
        chk("mid_rst_no_write", obs.size(), base);
        send_frame(16'h000A, 16'h0001);
        wait_writes(base + 1);
        chk("mid_rst_count", obs.size(), base + 1);
        chk_write("mid_rst", base, 16'h000A, 16'h0001, 1, 1'b0);

        // Random frames against the rule-level model of the register bank.
        base = obs.size();
        fb   = frame_cnt;
        for (int f = 0; f < 40; f++) begin
            ra = 16'($urandom);
            rd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rd[15:12] = 4'hD;
            e.addr = ra;
            e.data = rd;
            if (mapped(ra) && dly(rd) <= 15) begin
                e.width = dly(rd) + 1;
                e.nack  = 1'b0;
            end else begin
                e.width = 16;
                e.nack  = 1'b1;
            end
            expq.push_back(e);
            w = {ra, rd};
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_byte(w[31-8*k -: 8]);
            end
        end
        wait_writes(base + 40);
        chk("rand_count", obs.size(), base + 40);
        chk("rand_frame_err", frame_cnt - fb, 0);
        for (int i = 0; i < 40; i++) begin
            chk_write($sformatf("rand%0d", i), base + i, expq[i].addr, expq[i].data,
                      expq[i].width, expq[i].nack);
        end

        chk("rx_ack_during_write", viol, 0);
        chk("si_hold_stable", stab, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
